uart_tx_fifo: RTL and testbench

Byte FIFO between the CPU store path (MMU UART write decode) and the `uart_tx` serializer. CPU stores to the UART data address push one byte without waiting on the serial line. An internal drain FSM hands bytes to `uart_tx` one at a time through its `write_en`/`uart_busy` handshake. Status outputs (`full`, `empty`, `level`, `overflow`, `busy`) feed the MMU status-read path, so software polls the FIFO instead of `uart_busy`.

---
 rtl/uart_tx_fifo.sv | 148 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the CPU UART store path and the uart_tx serializer.
// A drain FSM hands one byte at a time to uart_tx and exposes FIFO status for software polling.
module uart_tx_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          clear_ovf,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          busy,
    output logic          tx_write_en,
    output logic [7:0]    tx_data,
    input  logic          tx_busy,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [1:0]    WAIT_LAST = 2'd3;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic [AW:0]   level_d;
    logic          overflow_q;
    logic          overflow_d;
    state_t        state_q;
    logic [1:0]    wait_cnt_q;
    logic [7:0]    tx_data_q;

    logic push_ok;
    logic push_rej;
    logic pop;

    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);
    assign level = level_q;

    // Handshake to uart_tx: tx_write_en is a one-cycle load strobe (valid) with tx_data stable;
    // uart_tx acknowledges by raising tx_busy, and a new byte is offered only after tx_busy
    // has been seen low again (or after the ack window expires without any ack).
    assign push_ok  = wr_en && !full;
    assign push_rej = wr_en && full;
    assign pop      = (state_q == IDLE) && !empty && !tx_busy;

    always_comb begin
        level_d = level_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // A rejected push in the same cycle as clear_ovf keeps the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (clear_ovf) begin
            overflow_d = 1'b0;
        end
        if (push_rej) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            level_q    <= level_d;
            overflow_q <= overflow_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= 2'd0;
            tx_data_q  <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        tx_data_q <= mem_q[rd_ptr_q];
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt_q <= 2'd0;
                    state_q    <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    // No ack within four cycles: treat the byte as consumed.
                    if (tx_busy) begin
                        state_q <= DRAIN;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 2'd1;
                    end
                end
                DRAIN: begin
                    if (!tx_busy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_write_en = (state_q == ISSUE);
    assign tx_data     = tx_data_q;
    assign overflow    = overflow_q;
    assign busy        = !empty || (state_q != IDLE);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based FIFO/drain model checked every cycle,
// a small uart_tx responder, and directed scenarios with literal expectations.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int FRAME = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clear_ovf;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic       busy;
    logic       tx_write_en;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .clear_ovf   (clear_ovf),
        .full        (full),
        .empty       (empty),
        .level       (level),
        .overflow    (overflow),
        .busy        (busy),
        .tx_write_en (tx_write_en),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: byte queue plus a drain engine counted in edges since the pop.
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_tx = 8'h00;
    bit         m_ovf = 1'b0;
    bit         m_engaged = 1'b0;
    bit         m_drain = 1'b0;
    bit         m_valid = 1'b0;
    int         m_edges = 0;

    always @(posedge clk) begin : model_b
        bit can_pop;
        bit full_pre;
        if (rst) begin
            m_q.delete();
            exp_q.delete();
            m_ovf     = 1'b0;
            m_engaged = 1'b0;
            m_drain   = 1'b0;
            m_edges   = 0;
            m_tx      = 8'h00;
            m_valid   = 1'b1;
        end else begin
            full_pre = (m_q.size() == DEPTH);
            can_pop  = !m_engaged && (m_q.size() != 0) && !tx_busy;
            if (m_engaged) begin
                m_edges++;
                if (m_edges >= 2) begin
                    if (m_drain) begin
                        if (!tx_busy) m_engaged = 1'b0;
                    end else if (tx_busy) begin
                        m_drain = 1'b1;
                    end else if (m_edges == 5) begin
                        m_engaged = 1'b0;
                    end
                end
            end
            if (clear_ovf) m_ovf = 1'b0;
            if (wr_en && full_pre) m_ovf = 1'b1;
            if (can_pop) begin
                m_tx = m_q.pop_front();
                exp_q.push_back(m_tx);
                m_engaged = 1'b1;
                m_drain   = 1'b0;
                m_edges   = 0;
            end
            if (wr_en && !full_pre) m_q.push_back(wr_data);
        end
    end

    always begin : compare_b
        logic [17:0] exp_vec;
        @(posedge clk);
        #1;
        if (m_valid) begin
            exp_vec = {5'(m_q.size()), m_q.size() == 0, m_q.size() == DEPTH, m_ovf,
                       (m_q.size() != 0) || m_engaged, m_engaged && (m_edges == 0), m_tx};
            chk("cycle_outputs", {level, empty, full, overflow, busy, tx_write_en, tx_data}, exp_vec);
        end
    end

    // uart_tx responder: records each strobed byte and holds tx_busy for a frame.
    int         frame_cnt = 0;
    bit         hold_busy = 1'b0;
    bit         mute = 1'b0;
    logic [7:0] rx_log[$];

    assign tx_busy = hold_busy || (frame_cnt != 0);

    always begin : uart_b
        @(posedge clk);
        #1;
        if (rst) begin
            frame_cnt = 0;
        end else begin
            if (frame_cnt != 0) frame_cnt--;
            if (tx_write_en) begin
                rx_log.push_back(tx_data);
                chk("pending_at_strobe", exp_q.size(), 1);
                if (exp_q.size() != 0) chk("tx_byte", tx_data, exp_q.pop_front());
                if (!mute) frame_cnt = FRAME;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = first + 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c = 0;
        while ((m_q.size() != 0 || m_engaged || tx_busy) && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk({name, "_drain_in_budget"}, 32'(c < budget), 1);
        chk({name, "_busy_low"}, busy, 0);
    endtask

    initial begin : watchdog_b
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main_b
        int c;
        int gap;
        int n_ee;
        rst       = 1'b1;
        wr_en     = 1'b1;
        wr_data   = 8'h55;
        clear_ovf = 1'b0;

        // Reset held two cycles with a push request present.
        tick(2);
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_write_en", tx_write_en, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        rst   = 1'b0;
        wr_en = 1'b0;
        tick(2);

        // Single byte: strobe two cycles after the push edge.
        rx_log.delete();
        wr_en   = 1'b1;
        wr_data = 8'h41;
        tick(1);
        wr_en = 1'b0;
        chk("single_level", level, 1);
        chk("single_no_early_strobe", tx_write_en, 0);
        tick(1);
        chk("single_strobe", tx_write_en, 1);
        chk("single_tx_data", tx_data, 8'h41);
        tick(1);
        chk("single_strobe_width", tx_write_en, 0);
        chk("single_busy_in_frame", busy, 1);
        wait_idle("single", 100);
        chk("single_rx_count", rx_log.size(), 1);
        chk("single_rx_byte", rx_log[0], 8'h41);

        // Ordering and wrap-around.
        rx_log.delete();
        hold_busy = 1'b1;
        push_seq(8'h00, 16);
        chk("wrap_full", full, 1);
        chk("wrap_level", level, 16);
        hold_busy = 1'b0;
        c = 0;
        while (m_q.size() != 8 && c < 400) begin
            tick(1);
            c++;
        end
        chk("wrap_half_drain_in_budget", 32'(c < 400), 1);
        push_seq(8'h10, 8);
        wait_idle("wrap", 1000);
        chk("wrap_rx_count", rx_log.size(), 24);
        for (int i = 0; i < 24; i++) chk("wrap_rx_order", rx_log[i], i);

        // Overflow: push while full on the same edge the FSM pops.
        rx_log.delete();
        hold_busy = 1'b1;
        push_seq(8'h20, 16);
        hold_busy = 1'b0;
        wr_en     = 1'b1;
        wr_data   = 8'hEE;
        tick(1);
        wr_en = 1'b0;
        chk("ovf_set", overflow, 1);
        chk("ovf_level", level, 15);
        clear_ovf = 1'b1;
        tick(1);
        clear_ovf = 1'b0;
        chk("ovf_cleared", overflow, 0);
        wait_idle("ovf", 1000);
        chk("ovf_rx_count", rx_log.size(), 16);
        n_ee = 0;
        for (int i = 0; i < rx_log.size(); i++) begin
            if (rx_log[i] == 8'hEE) n_ee++;
            chk("ovf_rx_order", rx_log[i], 32'h20 + i);
        end
        chk("ovf_ee_never_sent", n_ee, 0);

        // Simultaneous accepted push and pop at level 3.
        rx_log.delete();
        hold_busy = 1'b1;
        push_seq(8'h30, 3);
        hold_busy = 1'b0;
        wr_en     = 1'b1;
        wr_data   = 8'h33;
        tick(1);
        wr_en = 1'b0;
        chk("pushpop_level", level, 3);
        wait_idle("pushpop", 500);
        chk("pushpop_rx_count", rx_log.size(), 4);
        chk("pushpop_rx_last", rx_log[3], 8'h33);

        // Missing ack: strobes 6 cycles apart (ISSUE, 4 x WAIT_ACK, IDLE).
        rx_log.delete();
        mute = 1'b1;
        push_seq(8'h50, 2);
        c = 0;
        while (!tx_write_en && c < 20) begin
            tick(1);
            c++;
        end
        chk("noack_first_strobe_seen", tx_write_en, 1);
        gap = 0;
        do begin
            tick(1);
            gap++;
        end while (!tx_write_en && gap < 20);
        chk("noack_strobe_spacing", gap, 6);
        wait_idle("noack", 100);
        chk("noack_rx_count", rx_log.size(), 2);
        chk("noack_rx_second", rx_log[1], 8'h51);
        mute = 1'b0;

        // Reset while draining a frame with bytes still queued.
        push_seq(8'h60, 3);
        tick(1);
        chk("drain_state_before_rst", dbg_state, 2'd3);
        rst = 1'b1;
        tick(1);
        chk("midrst_level", level, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_full", full, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_tx_write_en", tx_write_en, 0);
        chk("midrst_overflow", overflow, 0);
        chk("midrst_tx_data", tx_data, 8'h00);
        chk("midrst_state", dbg_state, 2'd0);
        rst = 1'b0;
        tick(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
